// File: rtl/uart_mux_pkg.sv
// rtl/uart_mux_pkg.sv - shared defaults, header field layout, state encoding and header helpers for the UART muxes
package uart_mux_pkg;

    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_CHANNEL_BITS = 2;
    localparam int DEF_COUNTER_BITS = 16;

    localparam int HDR_CH_MSB   = DEF_DATA_BITS - 1;
    localparam int HDR_LEN_BITS = DEF_DATA_BITS - DEF_CHANNEL_BITS;

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        PAYLOAD = 2'd1,
        DISCARD = 2'd2
    } demux_state_t;

    // len is payload length minus one, so a header always carries at least one byte
    function automatic logic [DEF_DATA_BITS-1:0] hdr_encode(
        input logic [DEF_CHANNEL_BITS-1:0] ch,
        input logic [HDR_LEN_BITS-1:0]     len
    );
        return {ch, len};
    endfunction

    function automatic logic [DEF_CHANNEL_BITS-1:0] hdr_channel(input logic [DEF_DATA_BITS-1:0] hdr);
        return hdr[HDR_CH_MSB -: DEF_CHANNEL_BITS];
    endfunction

    function automatic logic [HDR_LEN_BITS-1:0] hdr_len(input logic [DEF_DATA_BITS-1:0] hdr);
        return hdr[HDR_LEN_BITS-1:0];
    endfunction

endpackage

// File: rtl/uart_out_demux_if.sv
// rtl/uart_out_demux_if.sv - USB RX FIFO pop side plus per-port TX FIFO write side of the output demux
interface uart_out_demux_if #(
    parameter int DATA_BITS  = 8,
    parameter int UART_COUNT = 4
);
    logic                  in_fifo_empty;
    logic [DATA_BITS-1:0]  in_fifo_data;
    logic                  in_fifo_read;
    logic [UART_COUNT-1:0] full;
    logic [UART_COUNT-1:0] write;
    logic [DATA_BITS-1:0]  data;

    modport master (
        input  in_fifo_empty, in_fifo_data, full,
        output in_fifo_read, write, data
    );

    modport slave (
        output in_fifo_empty, in_fifo_data, full,
        input  in_fifo_read, write, data
    );
endinterface

// File: rtl/uart_stall_timer.sv
// rtl/uart_stall_timer.sv - stall counter with a terminal pulse, used by the demux frame timeout
module uart_stall_timer #(
    parameter int COUNTER_BITS   = 16,
    parameter int TIMEOUT_CYCLES = 66000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expire
);
    // widen the counter when needed so the terminal count is always reachable
    localparam int LIMIT_BITS = $clog2(TIMEOUT_CYCLES);
    localparam int CW = (COUNTER_BITS > LIMIT_BITS) ? COUNTER_BITS : LIMIT_BITS;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign expire = tick && !clear && (count == LIMIT);

    always_ff @(posedge clk) begin
        if (reset || clear || expire) begin
            count <= '0;
        end else if (tick) begin
            count <= count + CW'(1);
        end
    end
endmodule

// File: rtl/uart_out_demux.sv
// rtl/uart_out_demux.sv - routes framed USB RX bytes to per-port UART TX FIFOs; UART_OUT_DEMUX_TIMEOUT_EN adds a stall timeout
module uart_out_demux
    import uart_mux_pkg::*;
#(
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int UART_COUNT   = 4,
    parameter int CHANNEL_BITS = DEF_CHANNEL_BITS
`ifdef UART_OUT_DEMUX_TIMEOUT_EN
    ,
    parameter int COUNTER_BITS   = DEF_COUNTER_BITS,
    parameter int TIMEOUT_CYCLES = 66000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    uart_out_demux_if.master bus,
    output logic             busy,
    output logic             frame_drop,
    output logic             frame_abort
);
    localparam int LEN_BITS = DATA_BITS - CHANNEL_BITS;
    localparam logic [CHANNEL_BITS:0] PORT_LIMIT = (CHANNEL_BITS + 1)'(UART_COUNT);

    demux_state_t            state, state_n;
    logic [CHANNEL_BITS-1:0] ch, ch_n;
    logic [LEN_BITS-1:0]     remaining, remaining_n;
    logic                    drop_n;
    logic [CHANNEL_BITS-1:0] hdr_chan;
    logic [LEN_BITS-1:0]     hdr_count;
    logic [UART_COUNT-1:0]   port_sel;
    logic                    port_full;
    logic                    pop;
    logic                    expire;

    assign hdr_chan  = bus.in_fifo_data[DATA_BITS-1 -: CHANNEL_BITS];
    assign hdr_count = bus.in_fifo_data[LEN_BITS-1:0];

    always_comb begin
        port_sel = '0;
        for (int i = 0; i < UART_COUNT; i++) begin
            port_sel[i] = (ch == CHANNEL_BITS'(i));
        end
    end

    // only the addressed port's full flag can hold up the active frame
    assign port_full = |(bus.full & port_sel);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HEADER;
            ch         <= '0;
            remaining  <= '0;
            frame_drop <= 1'b0;
        end else begin
            state      <= state_n;
            ch         <= ch_n;
            remaining  <= remaining_n;
            frame_drop <= drop_n;
        end
    end

    always_comb begin
        state_n     = state;
        ch_n        = ch;
        remaining_n = remaining;
        drop_n      = 1'b0;
        unique case (state)
            HEADER: begin
                if (pop) begin
                    ch_n        = hdr_chan;
                    remaining_n = hdr_count;
                    if ({1'b0, hdr_chan} < PORT_LIMIT) begin
                        state_n = PAYLOAD;
                    end else begin
                        state_n = DISCARD;
                        drop_n  = 1'b1;
                    end
                end
            end
            PAYLOAD, DISCARD: begin
                if (pop) begin
                    if (remaining == '0) begin
                        state_n = HEADER;
                    end else begin
                        remaining_n = remaining - LEN_BITS'(1);
                    end
                end else if (expire) begin
                    state_n = HEADER;
                end
            end
            default: state_n = HEADER;
        endcase
    end

    // strobes are held low during reset so no byte is lost to a frame being torn down
    always_comb begin
        pop       = 1'b0;
        bus.write = '0;
        if (!reset && !bus.in_fifo_empty) begin
            unique case (state)
                HEADER, DISCARD: pop = 1'b1;
                PAYLOAD: begin
                    pop       = !port_full;
                    bus.write = port_sel & {UART_COUNT{!port_full}};
                end
                default: pop = 1'b0;
            endcase
        end
    end

    assign bus.in_fifo_read = pop;
    assign bus.data         = bus.in_fifo_data;
    assign busy             = (state != HEADER);

`ifdef UART_OUT_DEMUX_TIMEOUT_EN
    uart_stall_timer #(
        .COUNTER_BITS  (COUNTER_BITS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_stall_timer (
        .clk   (clk),
        .reset (reset),
        .clear (!busy || pop),
        .tick  (busy && !pop),
        .expire(expire)
    );
    assign frame_abort = expire && !reset;
`else
    assign expire      = 1'b0;
    assign frame_abort = 1'b0;
`endif

endmodule

// File: doc/uart_out_demux.md
Name: uart_out_demux

Overview:
- Sits downstream of the USB UART receiver and upstream of the per-port UART transmitters; it is the host-to-device counterpart of the input mux.
- Pops framed bytes from the USB RX FIFO and decodes a one-byte header carrying channel and length.
- Routes the following payload bytes into the TX FIFO of the addressed UART port, one byte per clock when not stalled.

Parameters:
- DATA_BITS, 8, width of FIFO data bytes.
- UART_COUNT, 4, number of downstream UART ports (2..2**CHANNEL_BITS).
- CHANNEL_BITS, 2, header channel field width; must satisfy DATA_BITS - CHANNEL_BITS >= 1.
- COUNTER_BITS, 16, width of stall timer (optional feature only).
- TIMEOUT_CYCLES, 66000, stall limit in clk cycles (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_fifo_empty  in  1  USB RX FIFO empty.
- in_fifo_data  in  DATA_BITS  USB RX FIFO head byte; first-word-fall-through, valid whenever in_fifo_empty=0.
- in_fifo_read  out  1  pop strobe; pops the head byte in the same cycle.
- full  in  UART_COUNT  per-port TX FIFO full flags.
- write  out  UART_COUNT  per-port TX FIFO write strobes; at most one bit high.
- data  out  DATA_BITS  shared TX write data; equals in_fifo_data combinationally.
- busy  out  1  high while in PAYLOAD or DISCARD.
- frame_drop  out  1  one-cycle pulse when a header addresses a nonexistent port.
- frame_abort  out  1  one-cycle pulse on stall timeout; tied 0 without the optional feature.

Behaviour:
- Header format: channel = in_fifo_data[DATA_BITS-1 -: CHANNEL_BITS]; len = low DATA_BITS-CHANNEL_BITS bits. Payload length is len+1 (1..64 bytes at defaults).
- States: HEADER, PAYLOAD, DISCARD. Registers: state, ch (CHANNEL_BITS), remaining (DATA_BITS-CHANNEL_BITS).
- Reset: state=HEADER, ch=0, remaining=0. All strobes and pulses are 0, busy=0. Reset wins over every other event and aborts a frame mid-operation with no partial cleanup; remaining bytes of the aborted frame are then parsed as headers.
- HEADER: if !in_fifo_empty, then in_fifo_read=1, latch ch and remaining=len.
  - If ch < UART_COUNT, next state is PAYLOAD.
  - Otherwise next state is DISCARD, and frame_drop pulses in the cycle after the header pop (registered).
- PAYLOAD: transfer condition is !in_fifo_empty && !full[ch]. When it holds:
  - in_fifo_read=1 and write[ch]=1 in the same cycle, combinational from registered state and the input flags.
  - If remaining==0, next state is HEADER; else remaining decrements.
  - If the FIFO is empty or the port is full, both strobes are 0 and state holds.
  - Zero-bubble: the last payload byte and the next header are never consumed in the same cycle; the header pop occurs at the earliest on the following cycle.
- DISCARD: if !in_fifo_empty, then in_fifo_read=1 and write=0. The remaining countdown and HEADER return are identical to PAYLOAD. full is ignored.
- Throughput: 1 byte/cycle in PAYLOAD; header costs 1 cycle, so a frame of N payload bytes takes N+1 cycles with no stalls.
- Backpressure on the other ports never blocks the active frame; only full[ch] matters.
- in_fifo_read is never asserted when in_fifo_empty=1. write is never asserted to a full port.

Optional Feature:
- Macro: UART_OUT_DEMUX_TIMEOUT_EN.
- With the macro: a COUNTER_BITS stall counter clears on every pop and on entering HEADER, and increments each cycle in PAYLOAD/DISCARD without a pop.
  - On reaching TIMEOUT_CYCLES-1: state goes to HEADER, frame_abort pulses for one cycle, and the counter clears.
  - A pop in that same cycle takes priority: the byte transfers and the counter clears.
- Without the macro: no counter logic; frame_abort is constant 0; frames wait indefinitely.

Decomposition:
- Shared package uart_mux_pkg holds:
  - DATA_BITS/COUNTER_BITS defaults and CHANNEL_BITS.
  - Header field position/width constants: HDR_CH_MSB, HDR_LEN_BITS.
  - State encoding enum: HEADER, PAYLOAD, DISCARD.
  - Header encode/decode functions, reused by the input-mux framing and the benches.
- One natural sub-module: uart_stall_timer (counter + terminal pulse), instantiated only under UART_OUT_DEMUX_TIMEOUT_EN.

Test Plan:
- Single frame: push 0x42,0xA1,0xA2,0xA3, all full=0 -> write[1] high 3 consecutive cycles with data A1,A2,A3; busy high 3 cycles; state back to HEADER.
- Backpressure: header 0x01 then 0x55,0x66, full[0]=1 for 5 cycles after the header -> no write/read during the hold, then write[0] with 0x55 then 0x66 on consecutive cycles.
- Bad channel with UART_COUNT=3: push 0xC1,0x11,0x22,0x03,0x77 -> frame_drop pulses once; no write during the discard; then write[0] once with data 0x77.
- Empty gaps and reset: header 0x82, one byte, 4 empty cycles, one byte, then reset for 1 cycle -> 2 writes to port 2; after reset, busy=0 and the next byte 0x40 is treated as a header (channel 1, 1 byte).
- Timeout (macro on, TIMEOUT_CYCLES=10): header 0x03, 1 byte, then FIFO empty -> frame_abort pulses exactly 10 cycles after the last pop; the next byte is parsed as a header.
- Back-to-back frames 0x00,0xAA,0x40,0xBB -> write[0]/AA, one header cycle, then write[1]/BB; 4 cycles total.
